// File: rtl/maze_explorer.sv
// Depth-first maze walker driving a 16x16 bit-memory; marks visited cells and
// keeps the move history on a 256-entry direction stack readable after DONE.
module maze_explorer #(
  parameter logic [3:0] START_X = 4'd0,
  parameter logic [3:0] START_Y = 4'd0,
  parameter logic [3:0] GOAL_X  = 4'd15,
  parameter logic [3:0] GOAL_Y  = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       RD,
  output logic       WR,
  output logic       D_in,
  input  logic       D_out,
  output logic       done,
  output logic       fail,
  output logic [8:0] path_len,
  input  logic [7:0] path_idx,
  output logic [1:0] path_dir
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_MARK,
    S_PROBE,
    S_BACK,
    S_DONE,
    S_FAIL
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cur_x_q, cur_x_d;
  logic [3:0] cur_y_q, cur_y_d;
  logic [2:0] dir_q, dir_d;
  logic [8:0] sp_q, sp_d;
  logic [3:0] x_hold_q, y_hold_q;
  logic [1:0] stack_q [256];

  logic       rd, wr, push;
  logic [3:0] addr_x, addr_y;
  logic [3:0] nb_x, nb_y;
  logic       nb_off;
  logic [3:0] bk_x, bk_y;
  logic [7:0] top_idx;
  logic [1:0] top_dir;

  // Neighbour in the current probe direction; off-grid moves never wrap.
  always_comb begin
    nb_x   = cur_x_q;
    nb_y   = cur_y_q;
    nb_off = 1'b0;
    case (dir_q[1:0])
      2'd0: if (cur_x_q == 4'd15) nb_off = 1'b1; else nb_x = cur_x_q + 4'd1;
      2'd1: if (cur_y_q == 4'd15) nb_off = 1'b1; else nb_y = cur_y_q + 4'd1;
      2'd2: if (cur_x_q == 4'd0)  nb_off = 1'b1; else nb_x = cur_x_q - 4'd1;
      default: if (cur_y_q == 4'd0) nb_off = 1'b1; else nb_y = cur_y_q - 4'd1;
    endcase
  end

  assign top_idx = sp_q[7:0] - 8'd1;
  assign top_dir = stack_q[top_idx];

  // Undo the popped move to recover the cell we came from.
  always_comb begin
    bk_x = cur_x_q;
    bk_y = cur_y_q;
    case (top_dir)
      2'd0:    bk_x = cur_x_q - 4'd1;
      2'd1:    bk_y = cur_y_q - 4'd1;
      2'd2:    bk_x = cur_x_q + 4'd1;
      default: bk_y = cur_y_q + 4'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    dir_d   = dir_q;
    sp_d    = sp_q;
    rd      = 1'b0;
    wr      = 1'b0;
    push    = 1'b0;
    addr_x  = cur_x_q;
    addr_y  = cur_y_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d = S_CHK;
          sp_d    = 9'd0;
          cur_x_d = START_X;
          cur_y_d = START_Y;
          dir_d   = 3'd0;
        end
      end
      S_CHK: begin
        rd      = 1'b1;
        state_d = D_out ? S_FAIL : S_MARK;
      end
      S_MARK: begin
        wr = 1'b1;
        if (cur_x_q == GOAL_X && cur_y_q == GOAL_Y) begin
          state_d = S_DONE;
        end else begin
          dir_d   = 3'd0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        if (dir_q[2]) begin
          state_d = S_BACK;
        end else if (nb_off) begin
          dir_d = dir_q + 3'd1;
        end else begin
          rd     = 1'b1;
          addr_x = nb_x;
          addr_y = nb_y;
          if (!D_out) begin
            push    = 1'b1;
            sp_d    = sp_q + 9'd1;
            cur_x_d = nb_x;
            cur_y_d = nb_y;
            state_d = S_MARK;
          end else begin
            dir_d = dir_q + 3'd1;
          end
        end
      end
      S_BACK: begin
        if (sp_q == 9'd0) begin
          state_d = S_FAIL;
        end else begin
          sp_d    = sp_q - 9'd1;
          cur_x_d = bk_x;
          cur_y_d = bk_y;
          dir_d   = {1'b0, top_dir} + 3'd1;
          state_d = S_PROBE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cur_x_q  <= START_X;
      cur_y_q  <= START_Y;
      dir_q    <= 3'd0;
      sp_q     <= 9'd0;
      x_hold_q <= 4'd0;
      y_hold_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      dir_q   <= dir_d;
      sp_q    <= sp_d;
      if (rd || wr) begin
        x_hold_q <= addr_x;
        y_hold_q <= addr_y;
      end
    end
  end

  // Stack contents need no reset: sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[7:0]] <= dir_q[1:0];
  end

  assign RD       = rd;
  assign WR       = wr;
  assign D_in     = wr;
  assign X        = (rd || wr) ? addr_x : x_hold_q;
  assign Y        = (rd || wr) ? addr_y : y_hold_q;
  assign done     = (state_q == S_DONE);
  assign fail     = (state_q == S_FAIL);
  assign path_len = fail ? 9'd0 : sp_q;
  assign path_dir = stack_q[path_idx];

endmodule

// File: tb/tb_maze_explorer.sv
// Directed bench: behavioural 16x16 bit-memory plus hand-worked maze scenarios.
module tb_maze_explorer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   X, Y;
  logic         RD, WR, D_in, D_out;
  logic         done, fail;
  logic [8:0]   path_len;
  logic [7:0]   path_idx;
  logic [1:0]   path_dir;

  logic [255:0] mem;
  logic [255:0] map_img;
  logic         load_req;
  int           total = 0;
  int           bad = 0;
  int           wr_cnt = 0;
  int           rdwr_bad = 0;
  int           max_len = 0;

  maze_explorer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .X(X), .Y(Y), .RD(RD), .WR(WR), .D_in(D_in), .D_out(D_out),
    .done(done), .fail(fail), .path_len(path_len),
    .path_idx(path_idx), .path_dir(path_dir)
  );

  always #5 clk = ~clk;

  // Memory model: index = y*16 + x, combinational read, write at rising edge.
  assign D_out = mem[{Y, X}];
  always @(posedge clk) begin
    if (load_req) mem <= map_img;
    else if (WR) mem[{Y, X}] <= D_in;
  end

  always @(negedge clk) begin
    if (WR) wr_cnt++;
    if ((RD && WR) || (WR && !D_in)) rdwr_bad++;
    if (int'(path_len) > max_len) max_len = int'(path_len);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ones(input logic [255:0] v);
    int n = 0;
    for (int i = 0; i < 256; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic load_map(input logic [255:0] img);
    @(negedge clk);
    map_img  = img;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run(input int pulse_at, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && !fail && cyc < 20000) begin
      start = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("run_end", 32'(done | fail), 32'd1);
  endtask

  // Counts entries in [from,to] not equal to d; reports one comparison.
  task automatic check_path(input string tag, input int from, input int to, input logic [1:0] d);
    int errs = 0;
    for (int i = from; i <= to; i++) begin
      @(negedge clk);
      path_idx = 8'(i);
      #1;
      if (path_dir !== d) errs++;
    end
    check(tag, 32'(errs), 32'd0);
  endtask

  task automatic check_zero_run(input string tag, input int cyc);
    check({tag, "_cycles"}, 32'(cyc), 32'd77);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_len"}, 32'(path_len), 32'd30);
    check_path({tag, "_right"}, 0, 14, 2'd0);
    check_path({tag, "_down"}, 15, 29, 2'd1);
  endtask

  initial begin
    logic [255:0] img;
    int cyc;
    int w0;
    rst_n    = 1'b0;
    start    = 1'b0;
    path_idx = 8'd0;
    load_req = 1'b0;
    map_img  = '0;
    #12;
    check("rst_X", 32'(X), 32'd0);
    check("rst_Y", 32'(Y), 32'd0);
    check("rst_rdwr", 32'({RD, WR, D_in}), 32'd0);
    check("rst_flags", 32'({done, fail}), 32'd0);
    check("rst_len", 32'(path_len), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Open field: right along row 0, then down column 15.
    load_map('0);
    run(-1, cyc);
    check_zero_run("zero", cyc);
    img = '0;
    for (int i = 0; i < 16; i++) img[i] = 1'b1;
    for (int y = 1; y < 16; y++) img[y * 16 + 15] = 1'b1;
    check("zero_marks", 32'(ones(mem & img)), 32'd31);
    check("zero_ones", 32'(ones(mem)), 32'd31);

    // Start cell blocked.
    img = '0;
    img[0] = 1'b1;
    load_map(img);
    w0 = wr_cnt;
    run(-1, cyc);
    check("blk_cycles", 32'(cyc), 32'd1);
    check("blk_fail", 32'({done, fail}), 32'd1);
    check("blk_len", 32'(path_len), 32'd0);
    check("blk_wr", 32'(wr_cnt - w0), 32'd0);

    // Wall at column 1 except the bottom row.
    img = '0;
    for (int y = 0; y < 15; y++) img[y * 16 + 1] = 1'b1;
    load_map(img);
    run(-1, cyc);
    check("col_done", 32'(done), 32'd1);
    check("col_len", 32'(path_len), 32'd30);
    check_path("col_down", 0, 14, 2'd1);
    check_path("col_right", 15, 29, 2'd0);

    // Dead-end pocket along row 0 forces three pops before going down.
    img = '0;
    img[4] = 1'b1;
    img[16 + 1] = 1'b1;
    img[16 + 2] = 1'b1;
    img[16 + 3] = 1'b1;
    load_map(img);
    run(-1, cyc);
    check("bt_done", 32'(done), 32'd1);
    check("bt_len", 32'(path_len), 32'd30);
    check_path("bt_head", 0, 1, 2'd1);
    check_path("bt_row2", 2, 16, 2'd0);
    check_path("bt_col15", 17, 29, 2'd1);
    check("bt_deadend", 32'(mem[3:0]), 32'hf);
    check("bt_ones", 32'(ones(mem)), 32'd38);

    // Goal sealed off: whole reachable area explored, then failure.
    img = '0;
    img[15 * 16 + 14] = 1'b1;
    img[14 * 16 + 15] = 1'b1;
    load_map(img);
    w0 = wr_cnt;
    run(-1, cyc);
    check("enc_fail", 32'({done, fail}), 32'd1);
    check("enc_len", 32'(path_len), 32'd0);
    check("enc_goal", 32'(mem[255]), 32'd0);
    check("enc_ones", 32'(ones(mem)), 32'd255);
    check("enc_wr", 32'(wr_cnt - w0), 32'd253);

    // Asynchronous reset while probing the first neighbour.
    load_map('0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("probe_rd", 32'({RD, WR}), 32'd2);
    check("probe_X", 32'(X), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_X", 32'(X), 32'd0);
    check("arst_rdwr", 32'({RD, WR}), 32'd0);
    check("arst_flags", 32'({done, fail, path_len}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_map('0);
    run(-1, cyc);
    check_zero_run("post_rst", cyc);

    // Start pulse mid-run is ignored; start in DONE restarts at CHK.
    load_map('0);
    run(2, cyc);
    check_zero_run("ign", cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_chk", 32'({RD, WR, X, Y}), 32'h200);
    check("restart_len", 32'(path_len), 32'd0);
    @(posedge clk); #1;
    check("restart_fail", 32'(fail), 32'd1);

    check("rd_wr_excl", 32'(rdwr_bad), 32'd0);
    check("sp_bound", 32'(max_len <= 255), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
